// File: rtl/enemy_formation_mover.sv
// enemy_formation_mover: moves one row of enemies as a rigid formation that sweeps, reverses and drops.
// Handles tick timing, kills and end-of-wave detection; outputs decode straight from registers.
module enemy_formation_mover #(
   parameter int                   NUM_ENEMY = 4,
   parameter int                   X_W       = 10,
   parameter int                   Y_W       = 9,
   parameter logic [X_W+Y_W-1:0]   NONE      = {(X_W+Y_W){1'b1}},
   parameter logic [X_W-1:0]       START_X   = 10'd64,
   parameter logic [X_W-1:0]       SPACING   = 10'd48,
   parameter logic [Y_W-1:0]       ROW_Y     = 9'd108,
   parameter logic [X_W-1:0]       X_MIN     = 10'd16,
   parameter logic [X_W-1:0]       X_MAX     = 10'd608,
   parameter logic [X_W-1:0]       STEP      = 10'd1,
   parameter logic [Y_W-1:0]       DROP      = 9'd16,
   parameter logic [Y_W-1:0]       Y_MAX     = 9'd400,
   parameter logic [19:0]          STEP_DIV  = 20'd416_666
) (
   input  logic                           i_Clk,
   input  logic                           i_Rst,
   input  logic                           i_Enable,
   input  logic [NUM_ENEMY-1:0]           i_Hit,
   output logic [NUM_ENEMY-1:0]           o_EnemyState,
   output logic [NUM_ENEMY*(X_W+Y_W)-1:0] o_EnemyPosition,
   output logic [1:0]                     o_PhaseState,
   output logic                           o_AllDead,
   output logic                           o_Reached
);
   localparam int XW1 = X_W + 1;

   typedef enum logic [1:0] {PH_RIGHT = 2'b00, PH_LEFT = 2'b01, PH_DROP = 2'b10, PH_DONE = 2'b11} phase_t;

   if (NUM_ENEMY < 1 || NUM_ENEMY > 16 || STEP_DIV == 20'd0 || START_X < X_MIN ||
       int'(START_X) + (NUM_ENEMY - 1) * int'(SPACING) > int'(X_MAX)) begin : g_bad_params
      $error("enemy_formation_mover: illegal parameter set");
   end

   logic [X_W-1:0]       origin_q, origin_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic [NUM_ENEMY-1:0] alive_q, alive_d;
   phase_t               state_q, state_d, dir_q, dir_d;
   logic [19:0]          cnt_q, cnt_d;
   logic                 dead_q, dead_d, reached_q, reached_d;
   logic                 run, tick;
   int                   lo, hi;
   logic [XW1-1:0]       left_x, right_x;
   logic [Y_W:0]         y_drop;

   always_comb begin
      lo = 0;
      hi = 0;
      for (int k = NUM_ENEMY - 1; k >= 0; k--) if (alive_q[k]) lo = k;
      for (int k = 0; k < NUM_ENEMY; k++) if (alive_q[k]) hi = k;
      // one extra bit so the bound comparisons can never wrap
      left_x    = XW1'(origin_q) + XW1'(lo) * XW1'(SPACING);
      right_x   = XW1'(origin_q) + XW1'(hi) * XW1'(SPACING);
      y_drop    = {1'b0, y_q} + {1'b0, DROP};
      run       = i_Enable && state_q != PH_DONE;
      tick      = run && cnt_q == STEP_DIV - 20'd1;
      cnt_d     = run ? (tick ? '0 : cnt_q + 20'd1) : cnt_q;
      origin_d  = origin_q;
      y_d       = y_q;
      state_d   = state_q;
      dir_d     = dir_q;
      dead_d    = dead_q;
      reached_d = reached_q;
      alive_d   = alive_q & ~i_Hit;
      if (alive_d == '0) begin
         state_d = PH_DONE;
         dead_d  = 1'b1;
      end else if (tick) begin
         case (state_q)
            PH_RIGHT: if (right_x + XW1'(STEP) > XW1'(X_MAX)) begin
               state_d = PH_DROP;
               dir_d   = PH_LEFT;
            end else origin_d = origin_q + STEP;
            PH_LEFT: if (left_x < XW1'(X_MIN) + XW1'(STEP)) begin
               state_d = PH_DROP;
               dir_d   = PH_RIGHT;
            end else origin_d = origin_q - STEP;
            PH_DROP: begin
               y_d       = y_drop[Y_W-1:0];
               reached_d = y_drop >= {1'b0, Y_MAX};
               state_d   = reached_d ? PH_DONE : dir_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         origin_q  <= START_X;
         y_q       <= ROW_Y;
         alive_q   <= '1;
         state_q   <= PH_RIGHT;
         dir_q     <= PH_LEFT;
         cnt_q     <= '0;
         dead_q    <= 1'b0;
         reached_q <= 1'b0;
      end else begin
         origin_q  <= origin_d;
         y_q       <= y_d;
         alive_q   <= alive_d;
         state_q   <= state_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         dead_q    <= dead_d;
         reached_q <= reached_d;
      end
   end

   always_comb begin
      o_EnemyPosition = '0;
      for (int k = 0; k < NUM_ENEMY; k++)
         o_EnemyPosition[k*(X_W+Y_W) +: X_W+Y_W] = alive_q[k] ? {origin_q + X_W'(k) * SPACING, y_q} : NONE;
   end

   assign o_EnemyState = alive_q;
   assign o_PhaseState = state_q;
   assign o_AllDead    = dead_q;
   assign o_Reached    = reached_q;
endmodule

// File: tb/tb_enemy_formation_mover.sv
// tb_enemy_formation_mover: directed scenarios plus random enable/hit/reset traffic
// compared every cycle against an integer-level formation model.
module tb_enemy_formation_mover;
   localparam int SP = 48, X0 = 64, Y0 = 108, XMIN = 16, XMAX = 210, DIV = 4, DROPV = 16, YMAX = 140;

   logic        clk = 1'b0;
   logic        i_Rst = 1'b1, i_Enable = 1'b0;
   logic [3:0]  i_Hit = '0;
   logic [3:0]  o_EnemyState;
   logic [75:0] o_EnemyPosition;
   logic [1:0]  o_PhaseState;
   logic        o_AllDead, o_Reached;

   int n_checks = 0, n_fail = 0;
   int m_org, m_y, m_ph, m_dir, m_cnt;
   logic [3:0] m_alive;
   bit m_dead, m_reach;

   enemy_formation_mover #(
      .NUM_ENEMY(4), .X_MAX(10'd210), .STEP_DIV(20'd4), .Y_MAX(9'd140)
   ) dut (
      .i_Clk(clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Hit(i_Hit),
      .o_EnemyState(o_EnemyState), .o_EnemyPosition(o_EnemyPosition),
      .o_PhaseState(o_PhaseState), .o_AllDead(o_AllDead), .o_Reached(o_Reached)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input bit rst, input bit en, input logic [3:0] hit);
      bit tick;
      int lo, hi;
      logic [3:0] na;
      if (rst) begin
         m_org = X0; m_y = Y0; m_alive = 4'hf; m_ph = 0; m_dir = 1; m_cnt = 0; m_dead = 0; m_reach = 0;
      end else begin
         tick = en && m_ph != 3 && m_cnt == DIV - 1;
         if (en && m_ph != 3) m_cnt = tick ? 0 : m_cnt + 1;
         lo = -1;
         hi = -1;
         for (int k = 0; k < 4; k++) if (m_alive[k]) begin
            if (lo < 0) lo = k;
            hi = k;
         end
         na = m_alive & ~hit;
         if (na == 0) begin
            m_ph = 3;
            m_dead = 1;
         end else if (tick) begin
            if (m_ph == 0) begin
               if (m_org + hi * SP + 1 > XMAX) begin m_ph = 2; m_dir = 1; end
               else m_org++;
            end else if (m_ph == 1) begin
               if (m_org + lo * SP < XMIN + 1) begin m_ph = 2; m_dir = 0; end
               else m_org--;
            end else if (m_ph == 2) begin
               m_y += DROPV;
               if (m_y >= YMAX) begin m_ph = 3; m_reach = 1; end
               else m_ph = m_dir;
            end
         end
         m_alive = na;
      end
   endtask

   function automatic logic [31:0] exp_pos(int k);
      return m_alive[k] ? 32'((((m_org + k * SP) & 32'h3ff) << 9) | (m_y & 32'h1ff)) : 32'h7ffff;
   endfunction

   task automatic compare();
      chk("mask", 32'(o_EnemyState), 32'(m_alive));
      chk("phase", 32'(o_PhaseState), 32'(m_ph));
      chk("alldead", 32'(o_AllDead), 32'(m_dead));
      chk("reached", 32'(o_Reached), 32'(m_reach));
      for (int k = 0; k < 4; k++) chk($sformatf("pos%0d", k), 32'(o_EnemyPosition[k*19 +: 19]), exp_pos(k));
   endtask

   task automatic cyc(input bit rst, input bit en, input logic [3:0] hit);
      i_Rst = rst;
      i_Enable = en;
      i_Hit = hit;
      model(rst, en, hit);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      repeat (2) cyc(1, 0, 0);
      chk("reset_pos0", 32'(o_EnemyPosition[18:0]), (32'd64 << 9) | 32'd108);
      chk("reset_pos3", 32'(o_EnemyPosition[75:57]), (32'd208 << 9) | 32'd108);
      repeat (20) cyc(0, 0, 0);
      repeat (8) cyc(0, 1, 0);
      chk("origin_after_8", 32'(o_EnemyPosition[18:9]), 32'd66);
      repeat (10) cyc(0, 0, 0);
      repeat (12) cyc(0, 1, 0);
      cyc(0, 1, 4'b1000);
      chk("pos3_none", 32'(o_EnemyPosition[75:57]), 32'h7ffff);
      repeat (1000) cyc(0, 1, 0);
      chk("reached_dir", 32'(o_Reached), 32'd1);
      cyc(1, 0, 0);
      repeat (5) cyc(0, 1, 0);
      for (int i = 0; i < 8 && m_cnt != DIV - 1; i++) cyc(0, 1, 0);
      cyc(0, 1, 4'b1111);
      chk("alldead_dir", 32'(o_AllDead), 32'd1);
      repeat (20) cyc(0, 1, 0);
      cyc(1, 0, 0);
      repeat (30) cyc(0, 1, 0);
      cyc(1, 1, 0);
      chk("midsweep_reset_phase", 32'(o_PhaseState), 32'd0);
      for (int e = 0; e < 6; e++) begin
         cyc(1, 0, 0);
         repeat (1500) begin
            logic [3:0] h;
            h = ($urandom % 40 == 0) ? 4'($urandom) : 4'd0;
            cyc($urandom % 1000 == 0, $urandom % 4 != 0, h);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
